// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer
// Post-commit store queue for the out-of-order LSU. Committed stores are
// buffered in order and then written to the data memory port one at a time.
// Loads can check the buffer for overlapping bytes so that they do not
// bypass an older store that has not been written yet.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   commit_store           push one committed store (addr/wdata/be/uncached)
//   store_full/empty/count occupancy, all from the registered count
//   overflow_err           sticky: a push was attempted while full
//   mem_req/addr/wdata/be/uncached, mem_ack
//                          head-of-queue write handshake to memory
//   load_addr, load_be     load being checked; load_hit = overlap found
module lsu_store_buffer #(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         commit_store,
   input  logic [ADDR_WIDTH-1:0]        commit_addr,
   input  logic [31:0]                  commit_wdata,
   input  logic [3:0]                   commit_be,
   input  logic                         commit_uncached,
   output logic                         store_full,
   output logic                         store_empty,
   output logic [$clog2(DEPTH):0]       store_count,
   output logic                         overflow_err,
   output logic                         mem_req,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic [3:0]                   mem_be,
   output logic                         mem_uncached,
   input  logic                         mem_ack,
   input  logic [ADDR_WIDTH-1:0]        load_addr,
   input  logic [3:0]                   load_be,
   output logic                         load_hit
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   // Clears the byte-in-word bits so comparisons are word granular.
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [PTR_W-1:0]   head_reg, tail_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               overflow_reg;
   logic               push, pop;

   logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
   logic [31:0]           wdata_mem [DEPTH];
   logic [3:0]            be_mem    [DEPTH];
   logic                  unc_mem   [DEPTH];

   assign store_full   = (count_reg == CNT_W'(DEPTH));
   assign store_empty  = (count_reg == '0);
   assign store_count  = count_reg;
   assign overflow_err = overflow_reg;

   // Full comes from the registered count only: a pop in the same cycle
   // does not make room for a push.
   assign push       = commit_store && !store_full;
   assign pop        = (state_reg == REQ) && mem_ack;
   assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         if (push) tail_reg <= tail_reg + 1'b1;
         if (pop)  head_reg <= head_reg + 1'b1;
         if (commit_store && store_full) overflow_reg <= 1'b1;
      end
   end

   // Entry payload needs no reset; validity is implied by head/count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail_reg]  <= commit_addr;
         wdata_mem[tail_reg] <= commit_wdata;
         be_mem[tail_reg]    <= commit_be;
         unc_mem[tail_reg]   <= commit_uncached;
      end
   end

   // Drain FSM. IDLE waits one cycle after the first push so mem_req is
   // never raised in the push cycle; REQ streams entries back to back.
   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) state_next = REQ;
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ack && count_next == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_addr     = addr_mem[head_reg] & WORD_MASK;
   assign mem_wdata    = wdata_mem[head_reg];
   assign mem_be       = be_mem[head_reg];
   assign mem_uncached = unc_mem[head_reg];

   // Entry gi is occupied when its distance from head (mod DEPTH) is below
   // the count; this includes the head entry while it is in flight.
   logic [DEPTH-1:0] hit_vec;
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
         logic [PTR_W-1:0] offset;
         logic             occupied;
         assign offset      = PTR_W'(gi) - head_reg;
         assign occupied    = (CNT_W'(offset) < count_reg);
         assign hit_vec[gi] = occupied
                              && (((addr_mem[gi] ^ load_addr) & WORD_MASK) == '0)
                              && ((be_mem[gi] & load_be) != 4'b0000);
      end
   endgenerate

   assign load_hit = |hit_vec;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Self-checking bench for lsu_store_buffer. Expected memory writes are queued
// when stores are issued; a monitor pops and compares on each mem_req&&mem_ack.
module tb_lsu_store_buffer;

   localparam int DEPTH = 8;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          commit_store;
   logic [AW-1:0] commit_addr;
   logic [31:0]   commit_wdata;
   logic [3:0]    commit_be;
   logic          commit_uncached;
   logic          store_full, store_empty, overflow_err;
   logic [3:0]    store_count;
   logic          mem_req, mem_uncached, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic [AW-1:0] load_addr;
   logic [3:0]    load_be;
   logic          load_hit;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic        u;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   lsu_store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .commit_store(commit_store), .commit_addr(commit_addr),
      .commit_wdata(commit_wdata), .commit_be(commit_be),
      .commit_uncached(commit_uncached),
      .store_full(store_full), .store_empty(store_empty),
      .store_count(store_count), .overflow_err(overflow_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_uncached(mem_uncached), .mem_ack(mem_ack),
      .load_addr(load_addr), .load_be(load_be), .load_hit(load_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Drive a store for this cycle; queue its write only if it will be accepted.
   task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic u, input bit accept);
      wr_t e;
      commit_store    = 1'b1;
      commit_addr     = a;
      commit_wdata    = d;
      commit_be       = be;
      commit_uncached = u;
      if (accept) begin
         e.a  = {a[31:2], 2'b00};
         e.d  = d;
         e.be = be;
         e.u  = u;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: one compare per completed memory write.
   initial begin : monitor
      wr_t got, e;
      forever begin
         @(negedge clk);
         if (!rst && mem_req && mem_ack) begin
            got = {mem_addr, mem_wdata, mem_be, mem_uncached};
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL mem_write: got %0h, expected no write", got);
            end else begin
               e = exp_q.pop_front();
               chk("mem_write", 72'(got), 72'(e));
               $display("[TB] write addr=%08h data=%08h be=%b unc=%b", mem_addr, mem_wdata, mem_be, mem_uncached);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      commit_store = 1'b0; commit_addr = '0; commit_wdata = '0;
      commit_be = '0; commit_uncached = 1'b0; mem_ack = 1'b0;
      load_addr = '0; load_be = 4'hF;
      next_cycle();
      next_cycle();
      sample();
      chk("rst_empty", 72'(store_empty), 72'(1));
      chk("rst_full", 72'(store_full), 72'(0));
      chk("rst_count", 72'(store_count), 72'(0));
      chk("rst_ovf", 72'(overflow_err), 72'(0));
      chk("rst_req", 72'(mem_req), 72'(0));
      chk("rst_hit", 72'(load_hit), 72'(0));
      next_cycle();

      // Single store, ack tied high.
      rst = 1'b0;
      mem_ack = 1'b1;
      push_store(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1);
      sample();
      chk("t1_c0_req", 72'(mem_req), 72'(0));
      chk("t1_c0_empty", 72'(store_empty), 72'(1));
      next_cycle();
      commit_store = 1'b0;
      sample();
      chk("t1_c1_empty", 72'(store_empty), 72'(0));
      chk("t1_c1_count", 72'(store_count), 72'(1));
      chk("t1_c1_req", 72'(mem_req), 72'(0));
      next_cycle();
      sample();
      chk("t1_c2_req", 72'(mem_req), 72'(1));
      next_cycle();
      sample();
      chk("t1_c3_empty", 72'(store_empty), 72'(1));
      chk("t1_c3_req", 72'(mem_req), 72'(0));
      next_cycle();

      // Fill to full, overflow, then drain with no bubbles.
      mem_ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_store(32'h2000 + 32'(i * 4), 32'hA500_0000 | 32'(i),
                    4'(4'b0001 << (i % 4)), 1'(i % 2), 1);
         sample();
         chk("t2_fill_count", 72'(store_count), 72'(i));
         next_cycle();
      end
      push_store(32'h3000, 32'h0000_0BAD, 4'hF, 1'b0, 0);
      sample();
      chk("t2_full", 72'(store_full), 72'(1));
      chk("t2_count8", 72'(store_count), 72'(8));
      chk("t2_ovf_pre", 72'(overflow_err), 72'(0));
      next_cycle();
      commit_store = 1'b0;
      mem_ack = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sample();
         if (k == 0) chk("t2_ovf", 72'(overflow_err), 72'(1));
         chk("t2_drain_req", 72'(mem_req), 72'(1));
         chk("t2_drain_count", 72'(store_count), 72'(8 - k));
         next_cycle();
      end
      sample();
      chk("t2_empty", 72'(store_empty), 72'(1));
      chk("t2_idle_req", 72'(mem_req), 72'(0));
      chk("t2_ovf_sticky", 72'(overflow_err), 72'(1));
      mem_ack = 1'b0;
      next_cycle();

      // Steady state at count 3 with push and ack every cycle.
      for (int i = 0; i < 3; i++) begin
         push_store(32'h4000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF, 1'b0, 1);
         sample();
         next_cycle();
      end
      mem_ack = 1'b1;
      for (int j = 0; j < 20; j++) begin
         push_store(32'h4100 + 32'(j * 4), 32'hD000_0000 + 32'(j), 4'b1100, 1'(j % 2), 1);
         sample();
         chk("t3_count", 72'(store_count), 72'(3));
         next_cycle();
      end
      commit_store = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample();
         next_cycle();
      end
      sample();
      chk("t3_empty", 72'(store_empty), 72'(1));
      chk("t3_req", 72'(mem_req), 72'(0));
      mem_ack = 1'b0;
      next_cycle();

      // Load conflict check and a 5-cycle ack stall.
      push_store(32'h80, 32'h1111_2222, 4'b0011, 1'b0, 1);
      load_addr = 32'h80; load_be = 4'b0011;
      sample();
      chk("t4_same_cycle_hit", 72'(load_hit), 72'(0));
      next_cycle();
      push_store(32'h90, 32'h3333_4444, 4'b1111, 1'b1, 1);
      load_addr = 32'h80; load_be = 4'b0100;
      sample();
      chk("t4_hit_80_0100", 72'(load_hit), 72'(0));
      next_cycle();
      commit_store = 1'b0;
      for (int h = 0; h < 5; h++) begin
         case (h)
            0: begin load_addr = 32'h82; load_be = 4'b0010; end
            1: begin load_addr = 32'h84; load_be = 4'b1111; end
            2: begin load_addr = 32'h90; load_be = 4'b0001; end
            default: begin load_addr = 32'h82; load_be = 4'b0010; end
         endcase
         sample();
         case (h)
            0: chk("t4_hit_82_0010", 72'(load_hit), 72'(1));
            1: chk("t4_hit_84_1111", 72'(load_hit), 72'(0));
            2: chk("t4_hit_90_second", 72'(load_hit), 72'(1));
            default: chk("t4_hit_82_held", 72'(load_hit), 72'(1));
         endcase
         chk("t4_hold_req", 72'(mem_req), 72'(1));
         chk("t4_hold_addr", 72'(mem_addr), 72'(32'h80));
         chk("t4_hold_data", 72'(mem_wdata), 72'(32'h1111_2222));
         chk("t4_hold_be", 72'(mem_be), 72'(4'b0011));
         chk("t4_hold_count", 72'(store_count), 72'(2));
         next_cycle();
      end
      mem_ack = 1'b1;
      sample();
      next_cycle();
      mem_ack = 1'b0;
      load_addr = 32'h82; load_be = 4'b0010;
      sample();
      chk("t4_hit_after_ack", 72'(load_hit), 72'(0));
      chk("t4_single_pop", 72'(store_count), 72'(1));
      chk("t4_next_addr", 72'(mem_addr), 72'(32'h90));
      chk("t4_next_unc", 72'(mem_uncached), 72'(1));
      next_cycle();
      mem_ack = 1'b1;
      sample();
      next_cycle();
      mem_ack = 1'b0;
      sample();
      chk("t4_empty", 72'(store_empty), 72'(1));
      next_cycle();

      // Reset while a request is outstanding.
      for (int i = 0; i < 4; i++) begin
         push_store(32'h5000 + 32'(i * 4), 32'hE000_0000 + 32'(i), 4'hF, 1'b0, 1);
         sample();
         next_cycle();
      end
      commit_store = 1'b0;
      sample();
      chk("t5_pre_count", 72'(store_count), 72'(4));
      chk("t5_pre_req", 72'(mem_req), 72'(1));
      next_cycle();
      rst = 1'b1;
      exp_q.delete();
      sample();
      next_cycle();
      rst = 1'b0;
      sample();
      chk("t5_req", 72'(mem_req), 72'(0));
      chk("t5_count", 72'(store_count), 72'(0));
      chk("t5_empty", 72'(store_empty), 72'(1));
      chk("t5_ovf", 72'(overflow_err), 72'(0));
      next_cycle();
      next_cycle();
      sample();
      chk("t5_req_stays_low", 72'(mem_req), 72'(0));
      chk("all_writes_seen", 72'(exp_q.size()), 72'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
